lcd_result_ctrl: RTL

- Receiving end of the 2-bit LCD_sig result code produced by the game's score-comparison block.
- Initialises an HD44780-compatible 16x2 character LCD (8-bit bus, write-only).
- Writes a 16-character result message on line 1 whenever the result code changes.
- Sits between the game logic and the board's LCD header pins.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_byte_writer.sv | 108 ++++++++++
 rtl/lcd_result_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and init-sequence helper for the LCD
// result display controller.
`default_nettype none

package lcd_pkg;

    localparam logic [1:0] RES_PLAY = 2'b00;
    localparam logic [1:0] RES_A    = 2'b01;
    localparam logic [1:0] RES_B    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;

    typedef enum logic [2:0] {
        ST_PWR  = 3'd0,
        ST_INIT = 3'd1,
        ST_IDLE = 3'd2,
        ST_ADDR = 3'd3,
        ST_CHAR = 3'd4
    } state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC;
            2'd1:    return CMD_DISP;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLR;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_byte_writer.sv
// One HD44780 write cycle: bus setup, enable strobe, then a post-strobe
// wait (short or long), ending with a single-cycle done pulse.
`default_nettype none

module lcd_byte_writer #(
    parameter int T_SU  = 2,
    parameter int T_EN  = 10,
    parameter int T_CMD = 500,
    parameter int T_CLR = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    input  logic       long_wait_i,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o,
    output logic       done_o
);

    localparam int MAX_A = (T_SU > T_EN) ? T_SU : T_EN;
    localparam int MAX_B = (T_CMD > T_CLR) ? T_CMD : T_CLR;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_EN    = 2'd2,
        PH_WAIT  = 2'd3
    } phase_t;

    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic          long_q;
    logic          e_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          done_q;
    logic [CW-1:0] wait_len_d;

    assign wait_len_d = long_q ? CW'(T_CLR) : CW'(T_CMD);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                PH_IDLE: begin
                    if (start_i) begin
                        rs_q    <= rs_i;
                        data_q  <= data_i;
                        long_q  <= long_wait_i;
                        cnt_q   <= CW'(T_SU - 1);
                        phase_q <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= CW'(T_EN - 1);
                        phase_q <= PH_EN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PH_EN: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= wait_len_d - 1'b1;
                        done_q  <= (wait_len_d == CW'(1));
                        phase_q <= PH_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    // done is registered so it coincides with the last wait cycle
                    if (cnt_q == '0) begin
                        phase_q <= PH_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign done_o     = done_q;

endmodule

`default_nettype wire

// File: rtl/lcd_result_ctrl.sv
// LCD result display: powers up and initialises a 16x2 HD44780 panel, then
// rewrites line 1 with a fixed message whenever the game result code changes.
`default_nettype none

module lcd_result_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWR = 15000,
    parameter int T_SU  = 2,
    parameter int T_EN  = 10,
    parameter int T_CMD = 500,
    parameter int T_CLR = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] LCD_sig,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       busy
);

    localparam int PW = $clog2(T_PWR + 1);

    state_t        state_q;
    logic [PW-1:0] pwr_cnt_q;
    logic [3:0]    idx_q;
    logic [3:0]    idx_d;
    logic          start_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          long_q;
    logic          busy_q;
    logic          rw_q;
    logic [1:0]    msg_sel_q;
    logic [1:0]    shown_sig_q;
    logic          shown_valid_q;
    logic          wr_done;
    logic [7:0]    next_init_d;

    function automatic logic [7:0] msg_char(input logic [1:0] sel, input logic [3:0] idx);
        logic [127:0] line;
        logic [3:0]   pos;
        case (sel)
            RES_PLAY: line = "READY           ";
            RES_A:    line = "PLAYER A WINS   ";
            RES_B:    line = "PLAYER B WINS   ";
            RES_DRAW: line = "DRAW            ";
        endcase
        pos = 4'd15 - idx;
        return line[{pos, 3'b000} +: 8];
    endfunction

    assign idx_d       = idx_q + 4'd1;
    assign next_init_d = init_cmd(idx_d[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_PWR;
            pwr_cnt_q     <= '0;
            idx_q         <= 4'd0;
            start_q       <= 1'b0;
            rs_q          <= 1'b0;
            data_q        <= 8'h00;
            long_q        <= 1'b0;
            busy_q        <= 1'b1;
            rw_q          <= 1'b0;
            msg_sel_q     <= RES_PLAY;
            shown_sig_q   <= RES_PLAY;
            shown_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            rw_q    <= 1'b0;
            case (state_q)
                ST_PWR: begin
                    if (pwr_cnt_q == PW'(T_PWR - 1)) begin
                        state_q <= ST_INIT;
                        idx_q   <= 4'd0;
                        start_q <= 1'b1;
                        rs_q    <= 1'b0;
                        data_q  <= init_cmd(2'd0);
                        long_q  <= 1'b0;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (wr_done) begin
                        if (idx_q == 4'd3) begin
                            state_q       <= ST_IDLE;
                            shown_valid_q <= 1'b0;
                            busy_q        <= 1'b0;
                        end else begin
                            idx_q   <= idx_d;
                            start_q <= 1'b1;
                            data_q  <= next_init_d;
                            long_q  <= (next_init_d == CMD_CLR);
                        end
                    end
                end
                ST_IDLE: begin
                    // only the code present while idle matters; earlier ones are dropped
                    if (!shown_valid_q || (LCD_sig != shown_sig_q)) begin
                        msg_sel_q <= LCD_sig;
                        state_q   <= ST_ADDR;
                        busy_q    <= 1'b1;
                        start_q   <= 1'b1;
                        rs_q      <= 1'b0;
                        data_q    <= CMD_LINE1;
                        long_q    <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (wr_done) begin
                        state_q <= ST_CHAR;
                        idx_q   <= 4'd0;
                        start_q <= 1'b1;
                        rs_q    <= 1'b1;
                        data_q  <= msg_char(msg_sel_q, 4'd0);
                    end
                end
                ST_CHAR: begin
                    if (wr_done) begin
                        if (idx_q == 4'd15) begin
                            state_q       <= ST_IDLE;
                            shown_sig_q   <= msg_sel_q;
                            shown_valid_q <= 1'b1;
                            busy_q        <= 1'b0;
                        end else begin
                            idx_q   <= idx_d;
                            start_q <= 1'b1;
                            data_q  <= msg_char(msg_sel_q, idx_d);
                        end
                    end
                end
                default: begin
                    state_q <= ST_PWR;
                end
            endcase
        end
    end

    lcd_byte_writer #(
        .T_SU  (T_SU),
        .T_EN  (T_EN),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR)
    ) u_writer (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_q),
        .rs_i        (rs_q),
        .data_i      (data_q),
        .long_wait_i (long_q),
        .lcd_e_o     (LCD_E),
        .lcd_rs_o    (LCD_RS),
        .lcd_data_o  (LCD_DATA),
        .done_o      (wr_done)
    );

    assign LCD_RW = rw_q;
    assign busy   = busy_q;

endmodule

`default_nettype wire
